// File: rtl/sram_access_ctrl.sv
// rtl/sram_access_ctrl.sv - single-word access sequencer for a 1M x 16 asynchronous SRAM
module sram_access_ctrl #(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic              busy,
    output logic [ADDR_W-1:0] A,
    inout  wire  [DATA_W-1:0] Mem_bus,
    output logic              CE_N,
    output logic              OE_N,
    output logic              WE_N,
    output logic              UB_N,
    output logic              LB_N
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    state_t            state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    logic              we_q, we_nx;
    logic [1:0]        be_q, be_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [DATA_W-1:0] wdata_q, wdata_nx;
    logic              drive_q, drive_nx;
    logic              ce_n_nx, oe_n_nx, we_n_nx, ub_n_nx, lb_n_nx;
    logic              done_nx, busy_nx;

    // The controller owns the bus only while a write is in flight.
    assign Mem_bus = drive_q ? wdata_q : {DATA_W{1'bz}};

    // Next state, request capture, and the pin values for the state being entered.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        we_nx    = we_q;
        be_nx    = be_q;
        addr_nx  = A;
        wdata_nx = wdata_q;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nx = SETUP;
                    we_nx    = we;
                    be_nx    = be;
                    addr_nx  = addr;
                    wdata_nx = wdata;
                end
            end
            SETUP: begin
                state_nx = ACCESS;
                cnt_nx   = WAIT_LD;
            end
            ACCESS: begin
                if (cnt == 4'd1) state_nx = HOLD;
                else             cnt_nx   = cnt - 4'd1;
            end
            HOLD:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        // Pins are decoded from the upcoming state so they can be registered.
        ce_n_nx  = 1'b1;
        oe_n_nx  = 1'b1;
        we_n_nx  = 1'b1;
        ub_n_nx  = 1'b1;
        lb_n_nx  = 1'b1;
        drive_nx = 1'b0;
        busy_nx  = (state_nx != IDLE);
        done_nx  = (state_nx == HOLD);
        if (state_nx != IDLE) begin
            ce_n_nx = 1'b0;
            if (we_nx) begin
                ub_n_nx  = ~be_nx[1];
                lb_n_nx  = ~be_nx[0];
                drive_nx = 1'b1;
                we_n_nx  = (state_nx != ACCESS);
            end else begin
                ub_n_nx = 1'b0;
                lb_n_nx = 1'b0;
                oe_n_nx = (state_nx == HOLD);
            end
        end
    end

    // FSM state, wait counter and the captured request.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            be_q    <= 2'b00;
            A       <= '0;
            wdata_q <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            we_q    <= we_nx;
            be_q    <= be_nx;
            A       <= addr_nx;
            wdata_q <= wdata_nx;
        end
    end

    // Registered strobes and status so no input reaches a pin combinationally.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            CE_N    <= 1'b1;
            OE_N    <= 1'b1;
            WE_N    <= 1'b1;
            UB_N    <= 1'b1;
            LB_N    <= 1'b1;
            drive_q <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            CE_N    <= ce_n_nx;
            OE_N    <= oe_n_nx;
            WE_N    <= we_n_nx;
            UB_N    <= ub_n_nx;
            LB_N    <= lb_n_nx;
            drive_q <= drive_nx;
            done    <= done_nx;
            busy    <= busy_nx;
        end
    end

    // Capture read data as the last wait state ends, while OE_N is still low.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            rdata <= '0;
        end else if (state == ACCESS && cnt == 4'd1 && !we_q) begin
            rdata <= Mem_bus;
        end
    end

endmodule
